// File: rtl/serial_shift_rx.sv
// serial_shift_rx: oversampling receiver for a clock/data/clear/latch serial segment stream
module serial_shift_rx #(
    parameter int FRAME_BITS  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seg_clk_in,
    input  logic                  seg_sout_in,
    input  logic                  seg_clrn_in,
    input  logic                  seg_pen_in,
    input  logic                  frame_ready,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic [6:0]            bit_count,
    output logic                  frame_err,
    output logic                  overrun
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [6:0] FB = 7'(FRAME_BITS);

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0]      fill_q, fill_d;
    logic [3:0]                  synced;
    logic clk_prev_q, clk_prev_d, pen_prev_q, pen_prev_d, armed_q, armed_d;
    logic clk_evt_q, clk_evt_d, pen_evt_q, pen_evt_d, sout_q, sout_d, clrn_q, clrn_d;
    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
    logic [6:0]            cnt_q, cnt_d;
    logic bad_q, bad_d, valid_q, valid_d, err_q, err_d, ovr_q, ovr_d, good;

    assign synced = sync_q[SYNC_STAGES-1];

    // Edges count only once the chain holds real pin samples and seg_clk was seen low
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], {seg_clk_in, seg_sout_in, seg_clrn_in, seg_pen_in}};
        fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
        armed_d    = armed_q | (fill_q[SYNC_STAGES-1] & ~synced[3]);
        clk_prev_d = synced[3];
        pen_prev_d = synced[0];
        clk_evt_d  = synced[3] & ~clk_prev_q & armed_q;
        pen_evt_d  = synced[0] & ~pen_prev_q;
        sout_d     = synced[2];
        clrn_d     = synced[1];
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        data_d  = data_q;
        valid_d = valid_q & ~frame_ready;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        good    = 1'b0;
        if (!clrn_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
            bad_d   = 1'b0;
        end else begin
            if (clk_evt_q) begin
                shreg_d = {shreg_q[FRAME_BITS-2:0], sout_q};
                cnt_d   = (state_q == IDLE) ? 7'd1 : (&cnt_q ? cnt_q : cnt_q + 7'd1);
                bad_d   = ((state_q == SHIFT) & bad_q) | (cnt_d > FB);
                state_d = SHIFT;
            end
            if (pen_evt_q && state_q == SHIFT) begin
                good    = (cnt_d == FB) & ~bad_d;
                data_d  = good ? shreg_d : data_q;
                valid_d = good | valid_d;
                ovr_d   = good & valid_q & ~frame_ready;
                err_d   = ~good;
                state_d = IDLE;
                cnt_d   = '0;
                bad_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            fill_q     <= '0;
            armed_q    <= 1'b0;
            clk_prev_q <= 1'b0;
            pen_prev_q <= 1'b0;
            clk_evt_q  <= 1'b0;
            pen_evt_q  <= 1'b0;
            sout_q     <= 1'b0;
            clrn_q     <= 1'b0;
            state_q    <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            fill_q     <= fill_d;
            armed_q    <= armed_d;
            clk_prev_q <= clk_prev_d;
            pen_prev_q <= pen_prev_d;
            clk_evt_q  <= clk_evt_d;
            pen_evt_q  <= pen_evt_d;
            sout_q     <= sout_d;
            clrn_q     <= clrn_d;
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            bad_q      <= bad_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = valid_q;
    assign bit_count   = cnt_q;
    assign frame_err   = err_q;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_serial_shift_rx.sv
// tb_serial_shift_rx: directed checks of framing, errors, abort, handshake and reset recovery
module tb_serial_shift_rx;
    logic        clk = 1'b0, rst = 1'b1;
    logic        seg_clk_in = 1'b0, seg_sout_in = 1'b0, seg_clrn_in = 1'b1, seg_pen_in = 1'b0;
    logic        frame_ready = 1'b0;
    logic [63:0] frame_data;
    logic        frame_valid, frame_err, overrun;
    logic [6:0]  bit_count;
    int checks = 0, errors = 0;

    serial_shift_rx #(.FRAME_BITS(64), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .seg_clk_in(seg_clk_in), .seg_sout_in(seg_sout_in),
        .seg_clrn_in(seg_clrn_in), .seg_pen_in(seg_pen_in), .frame_ready(frame_ready),
        .frame_data(frame_data), .frame_valid(frame_valid), .bit_count(bit_count),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        seg_sout_in = b;
        seg_clk_in  = 1'b0;
        tick(4);
        seg_clk_in  = 1'b1;
        tick(4);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = 63; i >= 64 - n; i--) send_bit(v[i]);
    endtask

    // Caller has already raised seg_pen_in; the frame result lands 4 cycles later
    task automatic latch(input string tag, input logic [63:0] d, input logic v, input logic e, input logic o);
        tick(4);
        check({tag, ".valid"}, 64'(frame_valid), 64'(v));
        check({tag, ".err"}, 64'(frame_err), 64'(e));
        check({tag, ".ovr"}, 64'(overrun), 64'(o));
        check({tag, ".data"}, frame_data, d);
        tick(1);
        check({tag, ".err_off"}, 64'(frame_err), 64'd0);
        check({tag, ".ovr_off"}, 64'(overrun), 64'd0);
        check({tag, ".cnt0"}, 64'(bit_count), 64'd0);
        seg_pen_in = 1'b0;
        tick(2);
    endtask

    task automatic consume(input string tag);
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        check({tag, ".consumed"}, 64'(frame_valid), 64'd0);
    endtask

    initial begin
        tick(3);
        check("rst.valid", 64'(frame_valid), 64'd0);
        check("rst.data", frame_data, 64'd0);
        check("rst.cnt", 64'(bit_count), 64'd0);
        check("rst.err", 64'(frame_err), 64'd0);
        check("rst.ovr", 64'(overrun), 64'd0);
        rst = 1'b0;
        tick(6);

        send_bits(64'h0123456789ABCDEF, 64);
        check("good.cnt64", 64'(bit_count), 64'd64);
        seg_pen_in = 1'b1;
        tick(3);
        check("good.lat_early", 64'(frame_valid), 64'd0);
        tick(1);
        check("good.lat", 64'(frame_valid), 64'd1);
        check("good.err", 64'(frame_err), 64'd0);
        check("good.data", frame_data, 64'h0123456789ABCDEF);
        tick(2);
        seg_pen_in = 1'b0;
        tick(2);
        check("good.hold", frame_data, 64'h0123456789ABCDEF);
        consume("good");

        send_bits(64'hDEADBEEFCAFEF00D, 63);
        check("short.cnt63", 64'(bit_count), 64'd63);
        seg_pen_in = 1'b1;
        latch("short", 64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b0);
        send_bits(64'hDEADBEEFCAFEF00D, 64);
        send_bit(1'b1);
        check("long.cnt65", 64'(bit_count), 64'd65);
        seg_pen_in = 1'b1;
        latch("long", 64'h0123456789ABCDEF, 1'b0, 1'b1, 1'b0);

        send_bits(64'h5555AAAA5555AAAA, 30);
        check("abort.cnt30", 64'(bit_count), 64'd30);
        seg_clrn_in = 1'b0;
        tick(3);
        seg_clrn_in = 1'b1;
        tick(1);
        check("abort.cnt0", 64'(bit_count), 64'd0);
        check("abort.valid", 64'(frame_valid), 64'd0);
        tick(3);
        send_bits(64'hFFFF0000FFFF0000, 64);
        seg_pen_in = 1'b1;
        latch("abort_good", 64'hFFFF0000FFFF0000, 1'b1, 1'b0, 1'b0);
        consume("abort_good");

        send_bits(64'hA5A5A5A5A5A5A5A5, 64);
        seg_pen_in = 1'b1;
        latch("ovr_a", 64'hA5A5A5A5A5A5A5A5, 1'b1, 1'b0, 1'b0);
        send_bits(64'h3C3C3C3C3C3C3C3C, 64);
        seg_pen_in = 1'b1;
        latch("ovr_b", 64'h3C3C3C3C3C3C3C3C, 1'b1, 1'b0, 1'b1);
        send_bits(64'h0011223344556677, 64);
        seg_pen_in = 1'b1;
        tick(3);
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        check("same.valid", 64'(frame_valid), 64'd1);
        check("same.ovr", 64'(overrun), 64'd0);
        check("same.data", frame_data, 64'h0011223344556677);
        seg_pen_in = 1'b0;
        tick(2);
        consume("same");

        send_bits(64'h0F1E2D3C4B5A6978, 63);
        seg_sout_in = 1'b0;
        seg_clk_in  = 1'b0;
        tick(4);
        seg_clk_in  = 1'b1;
        seg_pen_in  = 1'b1;
        latch("coinc", 64'h0F1E2D3C4B5A6978, 1'b1, 1'b0, 1'b0);
        consume("coinc");

        send_bits(64'h9999888877776666, 40);
        check("rst40.cnt", 64'(bit_count), 64'd40);
        rst = 1'b1;
        tick(2);
        check("rst40.cnt0", 64'(bit_count), 64'd0);
        check("rst40.data0", frame_data, 64'd0);
        rst = 1'b0;
        tick(8);
        check("rst40.no_false_edge", 64'(bit_count), 64'd0);
        send_bits(64'h1122334455667788, 64);
        seg_pen_in = 1'b1;
        latch("rst40_good", 64'h1122334455667788, 1'b1, 1'b0, 1'b0);
        consume("rst40_good");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_shift_rx.md
SERIAL_SHIFT_RX -- requirements
Module: serial_shift_rx

Interface
REQ-001 Parameter FRAME_BITS, default 64, SHALL set the bits per frame (8 digits x 8 segments).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the flip-flop count of each input synchronizer (minimum 2).
REQ-003 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 seg_clk_in  input  1  SHALL carry the serial shift clock, treated as data and oversampled by clk.
REQ-006 seg_sout_in  input  1  SHALL carry the serial data, MSB first, valid at the seg_clk_in rising edge.
REQ-007 seg_clrn_in  input  1  SHALL be the active-low frame abort/clear.
REQ-008 seg_pen_in  input  1  SHALL be the latch enable; its rising edge ends a frame.
REQ-009 frame_ready  input  1  SHALL be the consumer accept signal.
REQ-010 frame_data  output  FRAME_BITS  SHALL hold the last accepted frame; bit FRAME_BITS-1 is the first bit received.
REQ-011 frame_valid  output  1  SHALL flag that frame_data is unconsumed.
REQ-012 bit_count  output  7  SHALL show the bits shifted in the current frame.
REQ-013 frame_err  output  1  SHALL be a one-cycle pulse on a bad-length frame.
REQ-014 overrun  output  1  SHALL be a one-cycle pulse when an unconsumed frame is overwritten.

Function
REQ-015 Each serial input SHALL pass through its own SYNC_STAGES synchronizer, with seg_sout_in delayed so it stays aligned with seg_clk_in.
REQ-016 A seg_clk edge event SHALL be synced seg_clk high this cycle and low the previous cycle; the seg_pen edge event SHALL be detected the same way.
REQ-017 The block SHALL implement the states IDLE and SHIFT.
REQ-018 In IDLE, a seg_clk edge event SHALL shift in the synced sout bit, set bit_count to 1 and move to SHIFT.
REQ-019 In SHIFT, each seg_clk edge event SHALL shift left (shreg <= {shreg[FRAME_BITS-2:0], bit}) and increment bit_count, saturating at 127.
REQ-020 Beyond FRAME_BITS bits, shifting SHALL continue (shreg keeps the last FRAME_BITS bits) and the frame SHALL be marked bad.
REQ-021 A seg_pen edge event in SHIFT with bit_count == FRAME_BITS SHALL load frame_data from shreg, set frame_valid, and return to IDLE with bit_count 0.
REQ-022 A seg_pen edge event in SHIFT with any other bit_count SHALL pulse frame_err, leave frame_data and frame_valid unchanged, and return to IDLE with bit_count 0.
REQ-023 A seg_pen edge event in IDLE SHALL be ignored, with no error.
REQ-024 When seg_clk and seg_pen edge events occur in the same cycle, the bit SHALL be counted before the length check.
REQ-025 Synced seg_clrn low SHALL force IDLE, bit_count 0 and shreg 0 on every cycle it is low.
REQ-026 seg_clrn low SHALL take priority over any simultaneous edge event and SHALL NOT alter frame_data or frame_valid.
REQ-027 frame_valid SHALL clear on the cycle after it is sampled high together with frame_ready.
REQ-028 frame_data SHALL remain stable while frame_valid is high, except as stated in REQ-029.
REQ-029 A good frame completing while frame_valid is high and frame_ready is low SHALL overwrite frame_data, keep frame_valid high, and pulse overrun.
REQ-030 A good frame completing in the same cycle as a frame_ready acceptance SHALL load new data, keep frame_valid high, and SHALL NOT pulse overrun.
REQ-031 Latency from a seg_pen_in rise at the pin to frame_valid high SHALL be SYNC_STAGES+2 clk cycles.

Reset
REQ-032 While rst is high, the block SHALL hold IDLE, shreg 0, bit_count 0, frame_data 0, frame_valid 0, frame_err 0, overrun 0, and all synchronizer and edge-detect flops 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; after release, the first bit SHALL be counted only on a fresh low-to-high seg_clk transition.

Verification
REQ-034 Good frame: send 64 bits 0x0123456789ABCDEF MSB first (seg_clk period 8 clk), then raise seg_pen -> frame_valid at SYNC_STAGES+2 cycles after the pin rise, frame_data = 0x0123456789ABCDEF, frame_err 0.
REQ-035 Short and long frames: send 63 bits and raise seg_pen -> frame_err one pulse, frame_valid stays 0; send 65 bits -> frame_err pulse.
REQ-036 Abort: send 30 bits, pulse seg_clrn low for 3 cycles, then send a good 64-bit frame 0xFFFF0000FFFF0000 -> bit_count reads 0 during the clear, frame_data = 0xFFFF0000FFFF0000.
REQ-037 Handshake and overrun: with frame_ready held 0, send two good frames A and B -> overrun pulses once and frame_data = B; assert frame_ready 1 cycle -> frame_valid low on the next cycle.
REQ-038 Coincident edges: align the 64th seg_clk rise with the seg_pen rise in the same clk cycle -> frame accepted, no frame_err; assert rst at bit 40, release, then send a full frame -> frame accepted with correct data.
